// File: rtl/system_top.sv
module system_top #(
    parameter string          ROM_FILE        = "",
    parameter logic [255:0]   ROM_IMAGE       = {{27{8'hA0}}, 8'h62, 8'h20, 8'h43, 8'h20, 8'h00},
    parameter int unsigned    RST_SYNC_STAGES = 2
) (
    input  logic sim_clock,
    input  logic power_on_reset_n,
    output logic HRESETn_top,
    output logic SYSRESETREQ_top_out,
    output logic LOCKUP_top_out,
    output logic TXEV_top_out
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_SEV    = 3'b001;
    localparam logic [2:0] OP_WAIT   = 3'b010;
    localparam logic [2:0] OP_JMP    = 3'b011;
    localparam logic [2:0] OP_RSTREQ = 3'b100;

    logic [RST_SYNC_STAGES-1:0] r_rst_sync;
    logic                       w_hresetn;
    logic [4:0]                 r_pc;
    logic [4:0]                 r_cnt;
    logic                       r_waiting;
    logic                       r_sysreq;
    logic                       r_lockup;
    logic                       r_txev;
    logic                       w_halted;
    logic [7:0]                 w_instr;
    logic [2:0]                 w_op;
    logic [4:0]                 w_arg;

    always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
        if (!power_on_reset_n)
            r_rst_sync <= '0;
        else
            r_rst_sync <= {r_rst_sync[RST_SYNC_STAGES-2:0], ~r_sysreq};
    end

    assign w_hresetn = r_rst_sync[RST_SYNC_STAGES-1];

    assign w_instr  = ROM_IMAGE[{r_pc, 3'b000} +: 8];
    assign w_op     = w_instr[7:5];
    assign w_arg    = w_instr[4:0];
    assign w_halted = r_sysreq | r_lockup;

    always_ff @(posedge sim_clock or negedge w_hresetn) begin
        if (!w_hresetn) begin
            r_pc      <= '0;
            r_cnt     <= '0;
            r_waiting <= 1'b0;
            r_sysreq  <= 1'b0;
            r_lockup  <= 1'b0;
            r_txev    <= 1'b0;
        end else begin
            r_txev <= 1'b0;
            if (!w_halted) begin
                case (w_op)
                    OP_NOP: r_pc <= r_pc + 5'd1;
                    OP_SEV: begin
                        r_txev <= 1'b1;
                        r_pc   <= r_pc + 5'd1;
                    end
                    OP_WAIT: begin
                        if (!r_waiting) begin
                            if (w_arg == 5'd0) begin
                                r_pc <= r_pc + 5'd1;
                            end else begin
                                r_cnt     <= w_arg;
                                r_waiting <= 1'b1;
                            end
                        end else if (r_cnt == 5'd1) begin
                            r_cnt     <= '0;
                            r_waiting <= 1'b0;
                            r_pc      <= r_pc + 5'd1;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    OP_JMP:    r_pc     <= w_arg;
                    OP_RSTREQ: r_sysreq <= 1'b1;
                    default:   r_lockup <= 1'b1;
                endcase
            end
        end
    end

    assign HRESETn_top         = w_hresetn;
    assign SYSRESETREQ_top_out = r_sysreq;
    assign LOCKUP_top_out      = r_lockup;
    assign TXEV_top_out        = r_txev;

endmodule

// File: tb/tb_system_top.sv
// Directed bench for system_top: five instances with different ROM images share
// clock and power-on reset; outputs are sampled mid-cycle against a timed table.
module tb_system_top;

    localparam logic [255:0] IMG_LOCK = {{31{8'hA0}}, 8'h00};
    localparam logic [255:0] IMG_RST  = {{30{8'h00}}, 8'h80, 8'h20};
    localparam logic [255:0] IMG_UND  = {{31{8'h00}}, 8'hE0};
    localparam logic [255:0] IMG_WRAP = {8'h62, {31{8'h20}}};

    typedef struct {
        int         t;
        int         dut;
        logic [3:0] exp;   // {HRESETn, SYSRESETREQ, LOCKUP, TXEV}
    } vec_t;

    logic sim_clock = 1'b0;
    logic power_on_reset_n;
    logic w_h [5];
    logic w_s [5];
    logic w_l [5];
    logic w_t [5];
    int   checks = 0;
    int   errors = 0;
    bit   u0_bad = 1'b0;
    vec_t vecs [$];

    always #50 sim_clock = ~sim_clock;

    system_top u0 (.sim_clock(sim_clock), .power_on_reset_n(power_on_reset_n),
        .HRESETn_top(w_h[0]), .SYSRESETREQ_top_out(w_s[0]), .LOCKUP_top_out(w_l[0]), .TXEV_top_out(w_t[0]));
    system_top #(.ROM_IMAGE(IMG_LOCK)) u1 (.sim_clock(sim_clock), .power_on_reset_n(power_on_reset_n),
        .HRESETn_top(w_h[1]), .SYSRESETREQ_top_out(w_s[1]), .LOCKUP_top_out(w_l[1]), .TXEV_top_out(w_t[1]));
    system_top #(.ROM_IMAGE(IMG_RST)) u2 (.sim_clock(sim_clock), .power_on_reset_n(power_on_reset_n),
        .HRESETn_top(w_h[2]), .SYSRESETREQ_top_out(w_s[2]), .LOCKUP_top_out(w_l[2]), .TXEV_top_out(w_t[2]));
    system_top #(.ROM_IMAGE(IMG_UND)) u3 (.sim_clock(sim_clock), .power_on_reset_n(power_on_reset_n),
        .HRESETn_top(w_h[3]), .SYSRESETREQ_top_out(w_s[3]), .LOCKUP_top_out(w_l[3]), .TXEV_top_out(w_t[3]));
    system_top #(.ROM_IMAGE(IMG_WRAP)) u4 (.sim_clock(sim_clock), .power_on_reset_n(power_on_reset_n),
        .HRESETn_top(w_h[4]), .SYSRESETREQ_top_out(w_s[4]), .LOCKUP_top_out(w_l[4]), .TXEV_top_out(w_t[4]));

    function automatic logic [3:0] st(input int d);
        return {w_h[d], w_s[d], w_l[d], w_t[d]};
    endfunction

    task automatic add(input int t, input int d, input logic [3:0] e);
        vec_t v;
        v.t = t; v.dut = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        if (t > $time) #(t - $time);
    endtask

    // The built-in program must never request reset or lock up while running.
    always @(negedge sim_clock)
        if ($time > 1200 && $time <= 30000 && (w_s[0] || w_l[0])) u0_bad = 1'b1;

    initial begin
        power_on_reset_n = 1'b1;
        #1 power_on_reset_n = 1'b0;

        add(1000, 0, 4'b0000); add(1000, 2, 4'b0000);
        add(1100, 0, 4'b0000);
        add(1200, 0, 4'b1000); add(1200, 3, 4'b1000);
        add(1300, 1, 4'b1000); add(1300, 2, 4'b1001); add(1300, 3, 4'b1010); add(1300, 4, 4'b1001);
        add(1400, 0, 4'b1001); add(1400, 1, 4'b1010); add(1400, 2, 4'b1100);
        add(1500, 0, 4'b1000); add(1500, 2, 4'b1100); add(1500, 3, 4'b1010);
        add(1600, 2, 4'b0000); add(1700, 2, 4'b0000); add(1800, 2, 4'b1000);
        add(1900, 0, 4'b1001); add(1900, 2, 4'b1001);
        add(2000, 0, 4'b1000); add(2000, 2, 4'b1100);
        add(2200, 2, 4'b0000);
        add(2400, 0, 4'b1000); add(2400, 2, 4'b1000);
        add(2500, 0, 4'b1001); add(2500, 2, 4'b1001);
        add(2800, 4, 4'b1001);
        add(3000, 0, 4'b1000); add(3100, 0, 4'b1001);
        add(4300, 4, 4'b1001); add(4400, 4, 4'b1000); add(4500, 4, 4'b1001);
        add(5000, 1, 4'b1010);
        add(7300, 4, 4'b1001); add(7400, 4, 4'b1000); add(7500, 4, 4'b1001);
        add(29400, 0, 4'b1000); add(29500, 0, 4'b1001);
        add(30000, 1, 4'b1010); add(30000, 3, 4'b1010);

        #1000 power_on_reset_n = 1'b1;   // released at t=1001

        for (int i = 0; i < vecs.size(); i++) begin
            wait_until(vecs[i].t);
            chk($sformatf("u%0d@%0d", vecs[i].dut, vecs[i].t), st(vecs[i].dut), vecs[i].exp);
        end
        chk("u0_no_lock_or_req", {3'b000, u0_bad}, 4'b0000);

        // Power-on reset dropped mid-WAIT: everything clears without a clock edge.
        wait_until(30310);
        power_on_reset_n = 1'b0;
        #1 chk("por_async_u0", st(0), 4'b0000);
        chk("por_async_u1", st(1), 4'b0000);
        chk("por_async_u3", st(3), 4'b0000);
        wait_until(30320);
        chk("por_hold_u0", st(0), 4'b0000);
        wait_until(30340);
        power_on_reset_n = 1'b1;
        wait_until(30400); chk("rel_sync_u0", st(0), 4'b0000);
        wait_until(30500); chk("rel_high_u0", st(0), 4'b1000);
        wait_until(30600); chk("rel_u1_pre", st(1), 4'b1000); chk("rel_u0_pre", st(0), 4'b1000);
        wait_until(30700); chk("rel_txev1", st(0), 4'b1001); chk("rel_u1_lock", st(1), 4'b1010);
        wait_until(30800); chk("rel_txev1_end", st(0), 4'b1000);
        wait_until(31200); chk("rel_txev2", st(0), 4'b1001);
        wait_until(31700); chk("rel_gap", st(0), 4'b1000);
        wait_until(31800); chk("rel_txev3", st(0), 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
